main_decoder: RTL and testbench
===============================

MAIN_DECODER -- requirements
Module: main_decoder

Interface
REQ-001 Parameters: none; the opcode width is fixed at 4 bits.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 op  input  4  instruction opcode, sampled every rising clk edge.
REQ-005 memread  output  1  data-memory read enable.
REQ-006 memwrite  output  1  data-memory write enable.
REQ-007 branch  output  1  conditional-branch (taken when ALU zero).
REQ-008 alusrc  output  1  ALU operand B: 0=register, 1=sign-extended immediate.
REQ-009 regdst  output  1  destination register: 0=rt field, 1=rd field.
REQ-010 regwrite  output  1  register-file write enable.
REQ-011 aluop  output  2  ALU class: 00=add, 01=subtract, 10=use funct field, 11=AND-immediate.
REQ-012 jump  output  1  unconditional jump.
REQ-013 illegal  output  1  high when the registered opcode is reserved or unknown.

Function
REQ-014 Decode SHALL be a full case on op, registered: outputs reflect the op sampled at the previous rising clk edge (latency 1 cycle, no handshake, a new op is accepted every cycle).
REQ-015 Opcode 0000 (R-type) SHALL produce regwrite=1, regdst=1, alusrc=0, aluop=10, all other outputs 0.
REQ-016 Opcode 0001 (LW) SHALL produce memread=1, regwrite=1, alusrc=1, regdst=0, aluop=00, all others 0.
REQ-017 Opcode 0010 (SW) SHALL produce memwrite=1, alusrc=1, aluop=00, regwrite=0, all others 0.
REQ-018 Opcode 0011 (BEQ) SHALL produce branch=1, alusrc=0, aluop=01, all others 0.
REQ-019 Opcode 0100 (ADDI) SHALL produce regwrite=1, alusrc=1, regdst=0, aluop=00, all others 0.
REQ-020 Opcode 1010 (ANDI) SHALL produce regwrite=1, alusrc=1, regdst=0, aluop=11, all others 0.
REQ-021 Opcode 1100 (NOP) SHALL produce all control outputs 0 and illegal=0.
REQ-022 Opcode 1110 (J) SHALL produce jump=1, all other outputs 0.
REQ-023 Every other opcode (0101-1001, 1011, 1101, 1111) SHALL produce all control outputs 0 and illegal=1.
REQ-024 An op containing X or Z bits SHALL take the default decode path: all control outputs 0 and illegal=1; no X SHALL propagate to any output.
REQ-025 memread and memwrite SHALL never both be 1; branch and jump SHALL never both be 1.
REQ-026 Outputs SHALL be glitch-free, driven directly from flops.

Reset
REQ-027 While reset=1, all outputs SHALL be 0, including aluop=00 and illegal=0, independent of clk.
REQ-028 Reset assertion mid-stream SHALL clear all outputs immediately and asynchronously, without waiting for a clk edge.
REQ-029 The first rising clk edge with reset=0 SHALL load the decode of the op present at that edge.

Structure
REQ-030 A shared package SHALL hold the opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_NOP, OP_J), the aluop encodings, and a packed control-word typedef.
REQ-031 The combinational opcode-to-control-word table SHALL be a sub-module named main_decoder_lut; main_decoder registers its result with the asynchronous reset.

Verification
REQ-032 Assert reset with op=0001, then release and clock once -> outputs stay 0 while reset=1; after the edge memread=1, regwrite=1, alusrc=1, aluop=00.
REQ-033 Apply op=xxxx, then 0001, 0000, 1100, 1110, 1010, one per cycle -> illegal=1; LW word; R-type word (regdst=1, aluop=10); all 0; jump=1; ANDI word (aluop=11), each one cycle later.
REQ-034 Sweep all 16 opcodes -> each output matches REQ-015..023; illegal=1 for exactly the 8 reserved codes.
REQ-035 Pulse reset mid-cycle while op=0000 is registered -> regwrite and regdst drop to 0 before the next clk edge.
REQ-036 Apply random op each cycle for 1000 cycles -> memread&memwrite and branch&jump are never both 1; outputs are never X after reset.

Source files
------------

// File: rtl/main_decoder_pkg.sv
// Shared opcode constants, ALU class encodings and the
// packed control word used by the main decoder.
package main_decoder_pkg;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_LW    = 4'b0001;
  localparam logic [3:0] OP_SW    = 4'b0010;
  localparam logic [3:0] OP_BEQ   = 4'b0011;
  localparam logic [3:0] OP_ADDI  = 4'b0100;
  localparam logic [3:0] OP_ANDI  = 4'b1010;
  localparam logic [3:0] OP_NOP   = 4'b1100;
  localparam logic [3:0] OP_J     = 4'b1110;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_ANDI  = 2'b11
  } aluop_e;

  typedef struct packed {
    logic   memread;
    logic   memwrite;
    logic   branch;
    logic   alusrc;
    logic   regdst;
    logic   regwrite;
    aluop_e aluop;
    logic   jump;
    logic   illegal;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/main_decoder_lut.sv
// Combinational opcode to control-word table; anything not
// listed (including X/Z opcodes) falls to the illegal path.
module main_decoder_lut
  import main_decoder_pkg::*;
(
  input  logic [3:0]        op_i,
  output logic [CTRL_W-1:0] ctrl_o
);

  ctrl_t c;

  always_comb begin
    c = '0;
    case (op_i)
      OP_RTYPE: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
        c.aluop    = ALU_FUNCT;
      end
      OP_LW: begin
        c.memread  = 1'b1;
        c.regwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.aluop    = ALU_ADD;
      end
      OP_SW: begin
        c.memwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.aluop    = ALU_ADD;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.aluop  = ALU_SUB;
      end
      OP_ADDI: begin
        c.regwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.aluop    = ALU_ADD;
      end
      OP_ANDI: begin
        c.regwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.aluop    = ALU_ANDI;
      end
      OP_NOP: c = '0;
      OP_J:   c.jump = 1'b1;
      default: c.illegal = 1'b1;
    endcase
  end

  assign ctrl_o = c;

endmodule

// File: rtl/main_decoder.sv
// Registered main control decoder: one-cycle latency,
// every output comes straight from a flop.
module main_decoder
  import main_decoder_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] op,
  output logic       memread,
  output logic       memwrite,
  output logic       branch,
  output logic       alusrc,
  output logic       regdst,
  output logic       regwrite,
  output logic [1:0] aluop,
  output logic       jump,
  output logic       illegal
);

  logic [CTRL_W-1:0] lut_w;
  ctrl_t             ctrl_d;
  ctrl_t             ctrl_q;

  main_decoder_lut u_lut (
    .op_i   (op),
    .ctrl_o (lut_w)
  );

  assign ctrl_d = ctrl_t'(lut_w);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign memread  = ctrl_q.memread;
  assign memwrite = ctrl_q.memwrite;
  assign branch   = ctrl_q.branch;
  assign alusrc   = ctrl_q.alusrc;
  assign regdst   = ctrl_q.regdst;
  assign regwrite = ctrl_q.regwrite;
  assign aluop    = ctrl_q.aluop;
  assign jump     = ctrl_q.jump;
  assign illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_main_decoder.sv
// Randomized self-checking bench for main_decoder against
// a rule-based reference of the opcode table.
module tb_main_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] op;
  logic       memread, memwrite, branch, alusrc;
  logic       regdst, regwrite, jump, illegal;
  logic [1:0] aluop;

  int n_chk  = 0;
  int n_pass = 0;

  main_decoder dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .memread  (memread),
    .memwrite (memwrite),
    .branch   (branch),
    .alusrc   (alusrc),
    .regdst   (regdst),
    .regwrite (regwrite),
    .aluop    (aluop),
    .jump     (jump),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  // {memread,memwrite,branch,alusrc,regdst,regwrite,aluop,jump,illegal}
  function automatic logic [9:0] dut_word();
    return {memread, memwrite, branch, alusrc, regdst,
            regwrite, aluop, jump, illegal};
  endfunction

  function automatic logic [9:0] model(logic [3:0] o);
    logic mr, mw, br, as, rd, rw, jp, il;
    logic [1:0] ao;
    int v;
    if ($isunknown(o)) return 10'b00_0000_0001;
    v  = int'(o);
    mr = (v == 1);
    mw = (v == 2);
    br = (v == 3);
    as = (v == 1) || (v == 2) || (v == 4) || (v == 10);
    rd = (v == 0);
    rw = (v == 0) || (v == 1) || (v == 4) || (v == 10);
    ao = (v == 0) ? 2'd2 : (v == 3) ? 2'd1 : (v == 10) ? 2'd3 : 2'd0;
    jp = (v == 14);
    il = !(v inside {0, 1, 2, 3, 4, 10, 12, 14});
    return {mr, mw, br, as, rd, rw, ao, jp, il};
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step(logic [3:0] v, string tag);
    op = v;
    @(posedge clk);
    #1;
    check(tag, 32'(dut_word()), 32'(model(v)));
  endtask

  initial begin
    reset = 1'b1;
    op    = 4'b0001;
    #1;
    check("rst_t0", 32'(dut_word()), 32'd0);
    @(posedge clk);
    #1;
    check("rst_edge", 32'(dut_word()), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("first_lw", 32'(dut_word()), 32'(model(4'b0001)));
    check("first_lw_lit", 32'(dut_word()), 32'b1001_0100_00);

    step(4'bxxxx, "seq_x");
    step(4'b0001, "seq_lw");
    step(4'b0000, "seq_r");
    check("seq_r_lit", 32'(dut_word()), 32'b0000_1110_00);
    step(4'b1100, "seq_nop");
    step(4'b1110, "seq_j");
    step(4'b1010, "seq_andi");
    check("seq_andi_aluop", 32'(aluop), 32'd3);

    for (int i = 0; i < 16; i++) begin
      step(4'(i), $sformatf("sweep_%0d", i));
    end

    step(4'b0000, "mid_pre");
    #2;
    reset = 1'b1;
    #1;
    check("mid_rw", 32'(regwrite), 32'd0);
    check("mid_rd", 32'(regdst), 32'd0);
    check("mid_all", 32'(dut_word()), 32'd0);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("mid_reload", 32'(dut_word()), 32'(model(4'b0000)));

    for (int i = 0; i < 1000; i++) begin
      step(4'($urandom_range(0, 15)), "rand");
      check("rand_mem", 32'(memread & memwrite), 32'd0);
      check("rand_bj", 32'(branch & jump), 32'd0);
      check("rand_x", 32'($isunknown(dut_word())), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
